// File: rtl/pio_window_bridge.sv
// pio_window_bridge
//   Bridges an asynchronous PIO bus (nCS0/nRD/nWR strobes, A22:A21 window
//   index, A4:A0 offset) onto a board bus with up to three 2 MiB memory
//   windows plus a local register block at window index 3.
//
// Ports
//   CLK       12 MHz board clock
//   nRESET    asynchronous reset, active-high
//   nCS0      PIO chip select, active-low
//   nRD, nWR  PIO read / write strobes, active-low
//   ADDR_HI   A22:A21 window index (3 = local registers)
//   ADDR_LO   A4:A0 register offset
//   PD        PIO-side data (tri-state)
//   D         board-side data (tri-state)
//   nCS_DEV   per-window chip selects, active-low
//   PAGE      high address bits per window, window i at [i*PAGE_BITS +: PAGE_BITS]
//   nIRQ_IN   device interrupts, active-low
//   nIN10     PIO interrupt, active-low
module pio_window_bridge #(
  parameter int DW        = 8,
  parameter int NUM_DEV   = 3,
  parameter int PAGE_BITS = 2,
  parameter int NUM_IRQ   = 4,
  parameter int HOLD_CYC  = 2
) (
  input  logic                           CLK,
  input  logic                           nRESET,
  input  logic                           nCS0,
  input  logic                           nRD,
  input  logic                           nWR,
  input  logic [1:0]                     ADDR_HI,
  input  logic [4:0]                     ADDR_LO,
  inout  wire  [DW-1:0]                  PD,
  inout  wire  [DW-1:0]                  D,
  output logic [NUM_DEV-1:0]             nCS_DEV,
  output logic [NUM_DEV*PAGE_BITS-1:0]   PAGE,
  input  logic [NUM_IRQ-1:0]             nIRQ_IN,
  output logic                           nIN10
);

  localparam logic [DW-1:0] ID_VAL   = DW'(8'hA4);
  localparam logic [3:0]    HOLD_END = 4'(HOLD_CYC - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ACT  = 3'd1,
    RD_HOLD = 3'd2,
    WR_ACT  = 3'd3,
    WR_HOLD = 3'd4
  } state_t;

  // ---- stage p0/p1: input synchronizers (inactive = 1) ----
  logic [2:0]         ctl_p0, ctl_p1;          // {nCS0, nRD, nWR}
  logic [NUM_IRQ-1:0] irq_p0, irq_p1, irq_p2;  // p2 only feeds edge detect
  logic [1:0]         flush;
  logic               armed;

  logic cs_act, rd_act, wr_act, rd_go, wr_go;

  assign cs_act = ~ctl_p1[2];
  assign rd_act = ~ctl_p1[1];
  assign wr_act = ~ctl_p1[0];

  // flush[1] marks that ctl_p1 holds a real sample rather than the reset
  // value; armed then waits for both strobes to be genuinely seen high, so
  // a strobe held low across reset release cannot start a cycle.
  always_ff @(posedge CLK or posedge nRESET) begin
    if (nRESET) begin
      ctl_p0 <= '1;
      ctl_p1 <= '1;
      irq_p0 <= '1;
      irq_p1 <= '1;
      irq_p2 <= '1;
      flush  <= '0;
      armed  <= 1'b0;
    end else begin
      ctl_p0 <= {nCS0, nRD, nWR};
      ctl_p1 <= ctl_p0;
      irq_p0 <= nIRQ_IN;
      irq_p1 <= irq_p0;
      irq_p2 <= irq_p1;
      flush  <= {flush[0], 1'b1};
      armed  <= armed | (flush[1] & ctl_p1[1] & ctl_p1[0]);
    end
  end

  assign rd_go = armed & cs_act & rd_act & ~wr_act;
  assign wr_go = armed & cs_act & wr_act & ~rd_act;

  // ---- bus FSM ----
  state_t       state, state_nx;
  logic [3:0]   hold_cnt;
  logic [1:0]   idx_q, idx_nx;
  logic [4:0]   off_q, off_nx;
  logic         enter_act, commit;
  logic         pd_oe, d_oe;
  logic [NUM_DEV-1:0] ncs_nx;

  always_ff @(posedge CLK or posedge nRESET) begin
    if (nRESET) begin
      state    <= IDLE;
      hold_cnt <= '0;
      idx_q    <= '0;
      off_q    <= '0;
      nCS_DEV  <= '1;
    end else begin
      state    <= state_nx;
      if ((state == RD_HOLD || state == WR_HOLD) && state_nx == state)
        hold_cnt <= hold_cnt + 4'd1;
      else
        hold_cnt <= '0;
      idx_q    <= idx_nx;
      off_q    <= off_nx;
      nCS_DEV  <= ncs_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (rd_go)      state_nx = RD_ACT;
        else if (wr_go) state_nx = WR_ACT;
      end
      RD_ACT:  if (!rd_act || !cs_act) state_nx = RD_HOLD;
      WR_ACT:  if (!wr_act || !cs_act) state_nx = WR_HOLD;
      RD_HOLD, WR_HOLD: begin
        if (rd_go)                     state_nx = RD_ACT;
        else if (wr_go)                state_nx = WR_ACT;
        else if (hold_cnt == HOLD_END) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Address is latched on every entry into an ACT state (from IDLE or from
  // a HOLD), and chip selects are registered from the next-state view so
  // they fall on the same edge the FSM enters ACT.
  always_comb begin
    enter_act = (state_nx == RD_ACT || state_nx == WR_ACT) &&
                !(state == RD_ACT || state == WR_ACT);
    idx_nx    = enter_act ? ADDR_HI : idx_q;
    off_nx    = enter_act ? ADDR_LO : off_q;
    pd_oe     = (state == RD_ACT) || (state == RD_HOLD);
    d_oe      = (state == WR_ACT) || (state == WR_HOLD);
    commit    = (state == WR_ACT) && (state_nx == WR_HOLD) && (idx_q == 2'd3);
    ncs_nx    = '1;
    if (state_nx != IDLE) begin
      for (int i = 0; i < NUM_DEV; i++)
        if (idx_nx == 2'(i)) ncs_nx[i] = 1'b0;
    end
  end

  // ---- local register block ----
  logic [PAGE_BITS-1:0] page_q [NUM_DEV];
  logic [NUM_IRQ-1:0]   mask_q, pend_q, irq_fall, pend_clr;
  logic [DW-1:0]        scratch_q, reg_rd, rd_live;
  logic [DW-1:0]        rd_cap, wr_cap;

  assign irq_fall = irq_p2 & ~irq_p1;
  assign pend_clr = (commit && off_q == 5'h05) ? wr_cap[NUM_IRQ-1:0] : '0;

  always_ff @(posedge CLK or posedge nRESET) begin
    if (nRESET) begin
      for (int i = 0; i < NUM_DEV; i++) page_q[i] <= '0;
      mask_q    <= '0;
      pend_q    <= '0;
      scratch_q <= '0;
      nIN10     <= 1'b1;
    end else begin
      for (int i = 0; i < NUM_DEV; i++)
        if (commit && off_q == 5'(i)) page_q[i] <= wr_cap[PAGE_BITS-1:0];
      if (commit && off_q == 5'h04) mask_q    <= wr_cap[NUM_IRQ-1:0];
      if (commit && off_q == 5'h06) scratch_q <= wr_cap;
      // a fresh edge wins over a coincident write-1-to-clear
      pend_q <= (pend_q & ~pend_clr) | irq_fall;
      nIN10  <= ~|(pend_q & mask_q);
    end
  end

  always_comb begin
    reg_rd = '0;
    case (off_nx)
      5'h04:   reg_rd[NUM_IRQ-1:0] = mask_q;
      5'h05:   reg_rd[NUM_IRQ-1:0] = pend_q;
      5'h06:   reg_rd = scratch_q;
      5'h07:   reg_rd = ID_VAL;
      default: begin
        for (int i = 0; i < NUM_DEV; i++)
          if (off_nx == 5'(i)) reg_rd[PAGE_BITS-1:0] = page_q[i];
      end
    endcase
    rd_live = (idx_nx == 2'd3) ? reg_rd : D;
  end

  // ---- data capture: sampled every cycle the FSM is (or is entering) ACT,
  // held through HOLD; the buses are driven from these registers ----
  always_ff @(posedge CLK) begin
    if (state_nx == RD_ACT) rd_cap <= rd_live;
    if (state_nx == WR_ACT) wr_cap <= PD;
  end

  assign PD = pd_oe ? rd_cap : {DW{1'bz}};
  assign D  = d_oe  ? wr_cap : {DW{1'bz}};

  for (genvar g = 0; g < NUM_DEV; g++) begin : g_page
    assign PAGE[g*PAGE_BITS +: PAGE_BITS] = page_q[g];
  end

endmodule

// File: tb/tb_pio_window_bridge.sv
module tb_pio_window_bridge;

  logic       CLK = 1'b0;
  logic       nRESET;
  logic       nCS0, nRD, nWR;
  logic [1:0] ADDR_HI;
  logic [4:0] ADDR_LO;
  tri1  [7:0] PD;
  tri1  [7:0] D;
  logic [2:0] nCS_DEV;
  logic [5:0] PAGE;
  logic [3:0] nIRQ_IN;
  logic       nIN10;

  logic [7:0] pd_drv, d_drv;
  logic       pd_en, d_en;
  logic [7:0] rdat;

  int n_cmp = 0;
  int n_bad = 0;

  assign PD = pd_en ? pd_drv : 8'hzz;
  assign D  = d_en  ? d_drv  : 8'hzz;

  always #5 CLK = ~CLK;

  pio_window_bridge dut (
    .CLK     (CLK),
    .nRESET  (nRESET),
    .nCS0    (nCS0),
    .nRD     (nRD),
    .nWR     (nWR),
    .ADDR_HI (ADDR_HI),
    .ADDR_LO (ADDR_LO),
    .PD      (PD),
    .D       (D),
    .nCS_DEV (nCS_DEV),
    .PAGE    (PAGE),
    .nIRQ_IN (nIRQ_IN),
    .nIN10   (nIN10)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic do_write(input logic [1:0] hi, input logic [4:0] lo, input logic [7:0] dat);
    ADDR_HI = hi; ADDR_LO = lo; pd_drv = dat; pd_en = 1'b1;
    nCS0 = 1'b0; nWR = 1'b0;
    step(4);
    nWR = 1'b1; nCS0 = 1'b1;
    step(3);
    pd_en = 1'b0;
    step(3);
  endtask

  task automatic do_read(input logic [1:0] hi, input logic [4:0] lo, output logic [7:0] dat);
    ADDR_HI = hi; ADDR_LO = lo;
    nCS0 = 1'b0; nRD = 1'b0;
    step(4);
    dat = PD;
    nRD = 1'b1; nCS0 = 1'b1;
    step(6);
  endtask

  initial begin
    nRESET = 1'b1; nCS0 = 1'b1; nRD = 1'b1; nWR = 1'b1;
    ADDR_HI = '0; ADDR_LO = '0; nIRQ_IN = 4'hF;
    pd_drv = '0; d_drv = '0; pd_en = 1'b0; d_en = 1'b0;

    // reset values
    step(3);
    check_val("rst_ncs",   nCS_DEV, 3'b111);
    check_val("rst_page",  PAGE,    6'h00);
    check_val("rst_nin10", nIN10,   1'b1);
    check_val("rst_pd",    PD,      8'hFF);
    check_val("rst_d",     D,       8'hFF);
    nRESET = 1'b0;
    step(5);

    // write 0x5A to window 0 with per-cycle checks
    ADDR_HI = 2'd0; ADDR_LO = 5'd0; pd_drv = 8'h5A; pd_en = 1'b1;
    nCS0 = 1'b0; nWR = 1'b0;
    step(2);
    check_val("w0_ncs_sync", nCS_DEV, 3'b111);
    step(1);
    check_val("w0_ncs_act", nCS_DEV, 3'b110);
    check_val("w0_d_act",   D,       8'h5A);
    step(1);
    check_val("w0_d_act2",  D,       8'h5A);
    nWR = 1'b1; nCS0 = 1'b1;
    step(3);
    pd_en = 1'b0;
    check_val("w0_d_hold1", D,       8'h5A);
    step(1);
    check_val("w0_d_hold2", D,       8'h5A);
    check_val("w0_ncs_hold", nCS_DEV, 3'b110);
    check_val("w0_pd_z",    PD,      8'hFF);
    step(1);
    check_val("w0_d_idle",  D,       8'hFF);
    check_val("w0_ncs_idle", nCS_DEV, 3'b111);
    step(2);

    // PAGE[1] via register offset 0x01, readback with no chip select
    do_write(2'd3, 5'h01, 8'h03);
    check_val("page1_out", PAGE, 6'h0C);
    ADDR_HI = 2'd3; ADDR_LO = 5'h01; nCS0 = 1'b0; nRD = 1'b0;
    step(4);
    check_val("page1_rd",  PD,      8'h03);
    check_val("page1_ncs", nCS_DEV, 3'b111);
    check_val("page1_d_z", D,       8'hFF);
    nRD = 1'b1; nCS0 = 1'b1;
    step(6);

    // only implemented page bits stored
    do_write(2'd3, 5'h00, 8'h07);
    do_read(2'd3, 5'h00, rdat);
    check_val("page0_rd",  rdat, 8'h03);
    check_val("page0_out", PAGE, 6'h0F);
    do_read(2'd3, 5'h07, rdat);
    check_val("id_rd", rdat, 8'hA4);
    do_read(2'd3, 5'h03, rdat);
    check_val("unmapped_rd", rdat, 8'h00);

    // read window 2 with D=0xC3
    ADDR_HI = 2'd2; ADDR_LO = 5'h00; d_drv = 8'hC3; d_en = 1'b1;
    nCS0 = 1'b0; nRD = 1'b0;
    step(4);
    check_val("r2_pd_act", PD,      8'hC3);
    check_val("r2_ncs",    nCS_DEV, 3'b011);
    nRD = 1'b1; nCS0 = 1'b1;
    step(2);
    check_val("r2_pd_rise2", PD, 8'hC3);
    step(1);
    d_en = 1'b0;
    check_val("r2_pd_hold1", PD, 8'hC3);
    step(1);
    check_val("r2_pd_hold2", PD, 8'hC3);
    step(1);
    check_val("r2_pd_idle",  PD,      8'hFF);
    check_val("r2_ncs_idle", nCS_DEV, 3'b111);
    step(2);

    // interrupts
    do_write(2'd3, 5'h04, 8'h01);
    check_val("irq_idle", nIN10, 1'b1);
    nIRQ_IN = 4'b1110;
    step(1);
    nIRQ_IN = 4'hF;
    step(4);
    check_val("irq_asserted", nIN10, 1'b0);
    do_read(2'd3, 5'h05, rdat);
    check_val("irq_pend", rdat, 8'h01);
    do_write(2'd3, 5'h05, 8'h01);
    check_val("irq_cleared", nIN10, 1'b1);
    do_read(2'd3, 5'h05, rdat);
    check_val("irq_pend_clr", rdat, 8'h00);

    // W1C coincident with a fresh edge
    ADDR_HI = 2'd3; ADDR_LO = 5'h05; pd_drv = 8'h01; pd_en = 1'b1;
    nCS0 = 1'b0; nWR = 1'b0;
    step(4);
    nWR = 1'b1; nCS0 = 1'b1; nIRQ_IN = 4'b1110;
    step(1);
    nIRQ_IN = 4'hF;
    step(2);
    pd_en = 1'b0;
    step(3);
    check_val("irq_coinc_nin10", nIN10, 1'b0);
    do_read(2'd3, 5'h05, rdat);
    check_val("irq_coinc_pend", rdat, 8'h01);

    // masked source sets pending but not nIN10
    do_write(2'd3, 5'h05, 8'h0F);
    nIRQ_IN = 4'b1101;
    step(1);
    nIRQ_IN = 4'hF;
    step(5);
    check_val("irq_masked_nin10", nIN10, 1'b1);
    do_read(2'd3, 5'h05, rdat);
    check_val("irq_masked_pend", rdat, 8'h02);

    // reset during WR_ACT with nWR held low across release
    ADDR_HI = 2'd3; ADDR_LO = 5'h06; pd_drv = 8'h77; pd_en = 1'b1;
    nCS0 = 1'b0; nWR = 1'b0;
    step(4);
    check_val("abort_d_act", D, 8'h77);
    nRESET = 1'b1;
    #1;
    check_val("abort_d_z",  D,       8'hFF);
    check_val("abort_ncs",  nCS_DEV, 3'b111);
    @(negedge CLK);
    check_val("abort_page",  PAGE,  6'h00);
    check_val("abort_nin10", nIN10, 1'b1);
    step(1);
    nRESET = 1'b0;
    step(8);
    check_val("abort_no_restart", D,       8'hFF);
    check_val("abort_ncs_idle",   nCS_DEV, 3'b111);
    nWR = 1'b1; nCS0 = 1'b1; pd_en = 1'b0;
    step(4);
    do_read(2'd3, 5'h06, rdat);
    check_val("abort_scratch", rdat, 8'h00);
    do_write(2'd3, 5'h06, 8'h77);
    do_read(2'd3, 5'h06, rdat);
    check_val("scratch_rd", rdat, 8'h77);

    // both strobes low
    ADDR_HI = 2'd0; ADDR_LO = 5'h00;
    nCS0 = 1'b0; nRD = 1'b0; nWR = 1'b0;
    step(5);
    check_val("both_ncs",  nCS_DEV, 3'b111);
    check_val("both_pd_z", PD,      8'hFF);
    check_val("both_d_z",  D,       8'hFF);
    nCS0 = 1'b1; nRD = 1'b1; nWR = 1'b1;
    step(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pio_window_bridge.md
PIO_WINDOW_BRIDGE -- requirements
Module: pio_window_bridge

Interface
REQ-001 The block SHALL have parameter DW, default 8, meaning PIO and board data bus width.
REQ-002 The block SHALL have parameter NUM_DEV, default 3, range 1..3, meaning number of 2 MiB memory windows.
REQ-003 The block SHALL have parameter PAGE_BITS, default 2, range 1..DW, meaning paging bits per window.
REQ-004 The block SHALL have parameter NUM_IRQ, default 4, range 1..DW, meaning number of interrupt sources.
REQ-005 The block SHALL have parameter HOLD_CYC, default 2, range 1..15, meaning CLK cycles of bus hold after a strobe rises.
REQ-006 The block SHALL have port CLK  in  1  12 MHz board clock.
REQ-007 The block SHALL have port nRESET  in  1  reset nRESET, asynchronous, active-high.
REQ-008 The block SHALL have port nCS0  in  1  PIO chip select, active-low.
REQ-009 The block SHALL have ports nRD and nWR  in  1 each  PIO read and write strobes, active-low.
REQ-010 The block SHALL have port ADDR_HI  in  2  A22:A21 window index.
REQ-011 The block SHALL have port ADDR_LO  in  5  A4:A0 register offset.
REQ-012 The block SHALL have port PD  inout  DW  PIO-side data.
REQ-013 The block SHALL have port D  inout  DW  board-side data.
REQ-014 The block SHALL have port nCS_DEV  out  NUM_DEV  per-window chip selects, active-low.
REQ-015 The block SHALL have port PAGE  out  NUM_DEV*PAGE_BITS  high address bits per window, window i at [i*PAGE_BITS +: PAGE_BITS].
REQ-016 The block SHALL have port nIRQ_IN  in  NUM_IRQ  device interrupts, active-low.
REQ-017 The block SHALL have port nIN10  out  1  PIO interrupt, active-low.

Function
REQ-018 nCS0, nRD, nWR and nIRQ_IN SHALL pass through 2-flop synchronizers; all decisions use synchronized values; ADDR sampled on ACTIVE entry.
REQ-019 Bus FSM states SHALL be IDLE, RD_ACT, RD_HOLD, WR_ACT, WR_HOLD.
REQ-020 IDLE->RD_ACT on sync CS0&RD&!WR; IDLE->WR_ACT on sync CS0&WR&!RD; RD and WR both low SHALL leave FSM in IDLE.
REQ-021 RD_ACT->RD_HOLD and WR_ACT->WR_HOLD when the sync strobe rises or CS0 rises.
REQ-022 HOLD states SHALL count HOLD_CYC cycles then go IDLE; a new valid strobe during HOLD SHALL go directly to the matching ACT state.
REQ-023 nCS_DEV[i] SHALL be low, registered, in ACT and HOLD states when the latched ADDR_HI==i and i<NUM_DEV; index 3 and unimplemented indices SHALL assert no nCS_DEV.
REQ-024 Synchronized strobe fall to nCS_DEV low SHALL be exactly 1 CLK.
REQ-025 RD_ACT: PD SHALL drive D (memory window) or register readback (index 3), D SHALL be high-Z; the value SHALL be captured every cycle.
REQ-026 RD_HOLD: PD SHALL drive the last captured value; D high-Z.
REQ-027 WR_ACT: D SHALL drive PD, captured every cycle; PD high-Z.
REQ-028 WR_HOLD: D SHALL drive the captured write value; PD high-Z.
REQ-029 IDLE: PD and D SHALL both be high-Z.
REQ-030 Register map at index 3, by ADDR_LO: 0x00..0x02 PAGE[0..2] (RW, implemented bits only, others read 0); 0x04 IRQ_MASK (RW, NUM_IRQ bits); 0x05 IRQ_PEND (read, write-1-to-clear); 0x06 SCRATCH (RW, DW bits); 0x07 ID (read-only 0xA4, truncated to DW); all other offsets read 0, ignore writes.
REQ-031 Register writes SHALL commit once, on the WR_ACT->WR_HOLD transition, using the captured value.
REQ-032 A synchronized falling edge of nIRQ_IN[k] SHALL set IRQ_PEND[k]; simultaneous set and W1C SHALL leave the bit set.
REQ-033 nIN10 SHALL be registered: ~|(IRQ_PEND & IRQ_MASK), updated 1 CLK after a pending or mask change.

Reset
REQ-034 While nRESET is high: FSM IDLE, nCS_DEV all 1, PD and D high-Z, PAGE 0, IRQ_MASK 0, IRQ_PEND 0, SCRATCH 0, nIN10 1, synchronizers set to inactive (1).
REQ-035 Reset asserted mid-cycle SHALL abort the cycle immediately; after release, a still-low strobe SHALL NOT start a cycle until it has been seen high.

Verification
REQ-036 Write 0x5A to index 0: nCS_DEV[0] low after 1 CLK from the synced strobe; D=0x5A through WR_ACT and HOLD_CYC=2 hold cycles, then high-Z.
REQ-037 Write 0x03 to offset 0x01 at index 3 (PAGE_BITS=2), then read it back: PAGE[3:2]=2'b11; PD=0x03; no nCS_DEV asserted.
REQ-038 Read window 2 with D=0xC3: PD=0xC3 while nRD is low and for 2 CLK after nRD rises, then high-Z.
REQ-039 Mask=0x01; pulse nIRQ_IN[0] low -> IRQ_PEND=0x01 and nIN10=0; write 0x01 to 0x05 -> nIN10=1; coincident new edge -> stays 0.
REQ-040 Assert nRESET during WR_ACT, with nWR held low across release -> outputs at reset values, no register commit, no new cycle until nWR is seen high.
REQ-041 nRD and nWR both low with nCS0 low -> FSM IDLE, no nCS_DEV asserted, PD and D high-Z.
